// File: rtl/mem_cmd_pkg.sv
// Shared types for the clocked memory command engine: opcodes, FSM states
// and the default-width command record used by drivers of the engine.
package mem_cmd_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FILL  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    FILL,
    RESP
  } state_e;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 8;
  localparam int CMD_LEN_W  = 4;

  typedef struct packed {
    op_e                   op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_LEN_W-1:0]  len;
  } mem_cmd_t;

endpackage

// File: rtl/mem_cmd_engine_mem_array.sv
// Single-port word array with synchronous write; the read path adds
// READ_LAT-1 register stages so the engine's own rdata flop completes the latency.
module mem_cmd_engine_mem_array #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int STAGES = READ_LAT - 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;

  // NOTE: storage has no reset; contents must survive rst_n and a reset
  // network on every word would buy nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rd_word = mem_q[addr];

  generate
    if (STAGES == 0) begin : g_direct
      assign rdata = rd_word;
    end else begin : g_pipe
      logic [DATA_W-1:0] pipe_q [STAGES];

      always_ff @(posedge clk) begin
        pipe_q[0] <= rd_word;
        for (int i = 1; i < STAGES; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign rdata = pipe_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/mem_cmd_engine.sv
// Registered command front end for a single-port memory: read with fixed
// latency, single write, constant block fill, range error and done pulse.
module mem_cmd_engine
  import mem_cmd_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 2,
  parameter int LEN_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LEN_W-1:0]  len,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  localparam int LAT_W = $clog2(READ_LAT + 1);

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic [DATA_W-1:0] arr_rdata;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // During FILL, cmd_q.addr is the running write pointer and cmd_q.len the
  // words still to go; the RESP error check only sees unmodified fields.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d = state_q;
    cmd_d   = cmd_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d = '{op: op_e'(op), addr: addr, wdata: wdata, len: len};
          lat_d = LAT_W'(READ_LAT - 1);
          if (op_e'(op) == OP_RSVD || !addr_in_range(addr)) begin
            state_d = RESP;
          end else begin
            unique case (op_e'(op))
              OP_READ:  state_d = RD;
              OP_WRITE: state_d = WR;
              default:  state_d = FILL;
            endcase
          end
        end
      end
      WR: begin
        mem_we  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RD: begin
        if (lat_q == '0) begin
          rdata_d = arr_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      FILL: begin
        mem_we = 1'b1;
        if (cmd_q.len == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cmd_d.len  = cmd_q.len - 1'b1;
          cmd_d.addr = next_addr(cmd_q.addr);
        end
      end
      RESP: begin
        done_d  = 1'b1;
        err_d   = (cmd_q.op == OP_RSVD) || !addr_in_range(cmd_q.addr);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  mem_cmd_engine_mem_array #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .READ_LAT (READ_LAT)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cmd_q.addr),
    .wdata (cmd_q.wdata),
    .rdata (arr_rdata)
  );

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: doc/mem_cmd_engine.md
Name: mem_cmd_engine

Overview:
Parametrised, clocked successor to the team's start/write memory model.
- Single-port memory array behind a registered command interface.
- Commands are sampled only on the clock edge, so there is no zero-delay race between driver and memory.
- Supports read, single write and multi-word fill (block write of a constant).
- Has configurable read latency, an address-range error flag and a one-cycle completion pulse.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data width in bits.
- DEPTH, 256, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- READ_LAT, 2, cycles from command acceptance to read data valid; must be >= 1.
- LEN_W, 4, width of the fill length field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command request; accepted at a rising edge when start && ready.
- op  in  2  command: 0 = READ, 1 = WRITE, 2 = FILL, 3 = reserved (treated as an error).
- addr  in  ADDR_W  start address.
- wdata  in  DATA_W  write/fill data.
- len  in  LEN_W  FILL only: number of words minus 1.
- ready  out  1  engine idle, command can be accepted.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: illegal op or addr >= DEPTH.
- rdata  out  DATA_W  read data; valid when done is high after a READ with err low.

Behaviour:
Reset (async assert, synchronous release):
- state = IDLE, ready = 1, done = 0, err = 0, rdata = 0.
- Memory contents are not reset and are retained across reset.

Acceptance (edge E0):
- op, addr, wdata and len are registered at E0.
- start while ready = 0 is ignored; it is not queued.
- ready = (state == IDLE).

FSM states: IDLE, WR, RD, FILL, RESP.
- IDLE goes to RESP on an error (op = 3, or addr >= DEPTH). No memory access occurs. done = err = 1 for the cycle after E1.
- WRITE: IDLE -> WR. mem[addr] <= wdata at E1. done pulses for the cycle after E1. State returns to IDLE at E1, so ready is high again after E1.
- READ: IDLE -> RD. A latency counter runs. rdata is loaded at E(READ_LAT), and done pulses in the following cycle. rdata holds its value until the next READ completes.
- FILL: IDLE -> FILL. The address increments modulo DEPTH: DEPTH-1 wraps to 0. The fill address range check applies only to the start address.
- FILL writes occur at E1 .. E(len+1), one word per cycle. done pulses after E(len+1). With len = 0 a FILL behaves exactly like WRITE.
- done and err are never high for more than one cycle per command.
- err = 0 whenever done = 0.
- Back-to-back commands: a start asserted in the cycle ready returns is accepted on that edge. There are no idle bubbles beyond the ones defined above.

Reset during an operation:
- Aborts immediately.
- Words already written stay written; the remaining fill words are not written.
- No done pulse is generated for the aborted command.

Decomposition:
Shared package mem_cmd_pkg holds:
- typedef enum logic [1:0] op_e {OP_READ, OP_WRITE, OP_FILL, OP_RSVD}.
- the state_e enum.
- a mem_cmd_t struct {op, addr, wdata, len}.

Sub-module mem_array:
- Plain synchronous single-port array with write enable.
- Read data pipelined to READ_LAT with a shift register.
- The FSM and counters stay in mem_cmd_engine.

Test Plan:
Defaults unless stated (READ_LAT = 2, DEPTH = 256).
1. WRITE addr 0x42 wdata 0x5A, then READ 0x42 -> write done 1 cycle after acceptance; read done 3 cycles after acceptance with rdata = 0x5A, err = 0.
2. FILL addr 0xFE len 3 wdata 0xA5, then READs of 0xFE, 0xFF, 0x00, 0x01 and 0x02 -> the first four return 0xA5 (wrap verified); 0x02 keeps its prior value; FILL done 4 cycles after acceptance.
3. DEPTH = 200: READ addr 0xC8, then op = 3 at addr 0x00 -> each gives done = err = 1 one cycle after acceptance; no memory change; rdata unchanged.
4. Hold start = 1 with op WRITE throughout a FILL len 7 -> the WRITE is accepted only on the edge ready returns (cycle 9); exactly two done pulses in total.
5. Assert rst_n = 0 mid-FILL (after 3 of 8 words) -> ready = 1 and done = 0 immediately; words 0-2 hold the fill value; words 3-7 are unchanged; no done pulse.
6. Assert start in the same cycle the engine becomes ready and drive WRITE/READ pairs back-to-back for 16 random addresses -> rdata matches a scoreboard and done count = 32.
